// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands (CRC7/end-bit checked)
// and serialises the card response after the Ncr gap. Optional macro: SD_RSP_TIMEOUT_EN.
module sd_card_cmd_responder #(
    parameter int unsigned NCR_MIN = 2,
    parameter int unsigned NCR_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en_i,
    input  logic        cmd_in_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o,
    output logic        cmd_valid_o,
    output logic        cmd_err_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        rsp_ready_o,
    input  logic        rsp_valid_i,
    input  logic        rsp_skip_i,
    input  logic [5:0]  rsp_index_i,
    input  logic [31:0] rsp_status_i,
    output logic        rsp_timeout_o
);

    localparam int unsigned FRAME_W  = 48;
    localparam int unsigned CRC_BITS = 40;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned NCR_W    = $clog2(NCR_MAX + 1);

    typedef enum logic [1:0] {IDLE, RX, WAIT_RSP, TX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NCR_W-1:0]   ncr_q, ncr_d;
    logic [6:0]         crc_q, crc_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               cmd_out_q, cmd_out_d;
    logic               cmd_oe_q, cmd_oe_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_err_q, cmd_err_d;
    logic [5:0]         cmd_index_q, cmd_index_d;
    logic [31:0]        cmd_arg_q, cmd_arg_d;
    logic               rsp_ready_q, rsp_ready_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               hs;
    logic [CNT_W-1:0]   bit_num;

    // Serial CRC7 step, G(x) = x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            ncr_q         <= '0;
            crc_q         <= '0;
            sr_q          <= '0;
            cmd_out_q     <= 1'b1;
            cmd_oe_q      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_index_q   <= '0;
            cmd_arg_q     <= '0;
            rsp_ready_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            ncr_q         <= ncr_d;
            crc_q         <= crc_d;
            sr_q          <= sr_d;
            cmd_out_q     <= cmd_out_d;
            cmd_oe_q      <= cmd_oe_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_err_q     <= cmd_err_d;
            cmd_index_q   <= cmd_index_d;
            cmd_arg_q     <= cmd_arg_d;
            rsp_ready_q   <= rsp_ready_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        ncr_d         = ncr_q;
        crc_d         = crc_q;
        sr_d          = sr_q;
        cmd_out_d     = cmd_out_q;
        cmd_oe_d      = cmd_oe_q;
        cmd_valid_d   = 1'b0;
        cmd_err_d     = cmd_err_q;
        cmd_index_d   = cmd_index_q;
        cmd_arg_d     = cmd_arg_q;
        rsp_ready_d   = rsp_ready_q;
        rsp_timeout_d = 1'b0;
        hs            = rsp_ready_q & rsp_valid_i;
        bit_num       = bit_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (bit_en_i && !cmd_in_i) begin
                    state_d   = RX;
                    bit_cnt_d = CNT_W'(1);
                    crc_d     = '0;
                    sr_d      = '0;
                end
            end
            RX: begin
                if (bit_en_i) begin
                    sr_d      = {sr_q[FRAME_W-2:0], cmd_in_i};
                    bit_cnt_d = bit_num;
                    if (bit_num <= CNT_W'(CRC_BITS)) begin
                        crc_d = crc7_step(crc_q, cmd_in_i);
                    end
                    // dir=0 means another card's response on the bus
                    if (bit_num == CNT_W'(2) && !cmd_in_i) begin
                        state_d = IDLE;
                    end else if (bit_num == CNT_W'(FRAME_W)) begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = sr_q[44:39];
                        cmd_arg_d   = sr_q[38:7];
                        cmd_err_d   = (sr_q[6:0] != crc_q) || !cmd_in_i;
                        bit_cnt_d   = '0;
                        ncr_d       = '0;
                        if ((sr_q[6:0] != crc_q) || !cmd_in_i) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = WAIT_RSP;
                            rsp_ready_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (bit_en_i && ncr_q != NCR_W'(NCR_MAX)) begin
                    ncr_d = ncr_q + NCR_W'(1);
                end
                if (hs) begin
                    rsp_ready_d = 1'b0;
                    if (rsp_skip_i) begin
                        state_d = IDLE;
                    end else begin
                        sr_d = {2'b00, rsp_index_i, rsp_status_i, 7'b0, 1'b1};
                    end
                end else if (!rsp_ready_q && bit_en_i && ncr_q >= NCR_W'(NCR_MIN)) begin
                    // response accepted earlier: drive the start bit now
                    state_d   = TX;
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = sr_q[FRAME_W-1];
                    sr_d      = {sr_q[FRAME_W-2:0], 1'b0};
                    crc_d     = crc7_step(7'b0, sr_q[FRAME_W-1]);
                    bit_cnt_d = CNT_W'(1);
                end
`ifdef SD_RSP_TIMEOUT_EN
                else if (rsp_ready_q && bit_en_i && ncr_q == NCR_W'(NCR_MAX - 1)) begin
                    rsp_timeout_d = 1'b1;
                    rsp_ready_d   = 1'b0;
                    state_d       = IDLE;
                end
`endif
            end
            TX: begin
                if (bit_en_i) begin
                    if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                        state_d   = IDLE;
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_num;
                        if (bit_num <= CNT_W'(CRC_BITS)) begin
                            cmd_out_d = sr_q[FRAME_W-1];
                            sr_d      = {sr_q[FRAME_W-2:0], 1'b0};
                            crc_d     = crc7_step(crc_q, sr_q[FRAME_W-1]);
                        end else if (bit_num < CNT_W'(FRAME_W)) begin
                            cmd_out_d = crc_q[6];
                            crc_d     = {crc_q[5:0], 1'b0};
                        end else begin
                            cmd_out_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_out_o     = cmd_out_q;
    assign cmd_oe_o      = cmd_oe_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_err_o     = cmd_err_q;
    assign cmd_index_o   = cmd_index_q;
    assign cmd_arg_o     = cmd_arg_q;
    assign rsp_ready_o   = rsp_ready_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: host-side frame driver, card-logic
// handshake, and monitors comparing decoded commands and response frames to a model.
module tb_sd_card_cmd_responder;

    localparam int unsigned NCR_MIN = 2;
    localparam int unsigned NCR_MAX = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_en = 1'b0;
    logic        cmd_in = 1'b1;
    logic        cmd_out, cmd_oe, cmd_valid, cmd_err;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rsp_ready;
    logic        rsp_valid = 1'b0;
    logic        rsp_skip = 1'b0;
    logic [5:0]  rsp_index = '0;
    logic [31:0] rsp_status = '0;
    logic        rsp_timeout;

    sd_card_cmd_responder #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
        .clk(clk), .reset(reset), .bit_en_i(bit_en), .cmd_in_i(cmd_in),
        .cmd_out_o(cmd_out), .cmd_oe_o(cmd_oe), .cmd_valid_o(cmd_valid),
        .cmd_err_o(cmd_err), .cmd_index_o(cmd_index), .cmd_arg_o(cmd_arg),
        .rsp_ready_o(rsp_ready), .rsp_valid_i(rsp_valid), .rsp_skip_i(rsp_skip),
        .rsp_index_i(rsp_index), .rsp_status_i(rsp_status), .rsp_timeout_o(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Bit strobe with a random 1..4 cycle period
    int gap_left = 0;
    always @(posedge clk) begin
        if (gap_left == 0) begin
            bit_en   <= 1'b1;
            gap_left <= int'($urandom_range(3, 0));
        end else begin
            bit_en   <= 1'b0;
            gap_left <= gap_left - 1;
        end
    end

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        err;
    } cmd_exp_t;

    typedef struct {
        logic [47:0] frame;
        int          exp_n;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] make_rsp(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, crc7({2'b00, idx, st}), 1'b1};
    endfunction

    // Command decode monitor
    cmd_exp_t ce;
    always @(negedge clk) begin
        if (!reset && cmd_valid) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_cmd_valid", 64'(cmd_index), 64'hFFFF);
            end else begin
                ce = cmd_q.pop_front();
                check("cmd_index", 64'(cmd_index), 64'(ce.idx));
                check("cmd_arg", 64'(cmd_arg), 64'(ce.arg));
                check("cmd_err", 64'(cmd_err), 64'(ce.err));
            end
        end
    end

    // Response line monitor: Ncr gap, frame contents, idle level
    int          since_valid = 0;
    logic        prev_oe = 1'b0;
    bit          collecting = 1'b0;
    int          nbits = 0;
    logic [47:0] got = '0;
    rsp_exp_t    re;
    always @(negedge clk) begin
        if (reset) begin
            collecting = 1'b0;
            prev_oe    = 1'b0;
        end else begin
            if (cmd_valid) since_valid = 0;
            if (cmd_oe && !prev_oe) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_cmd_oe", 64'(cmd_oe), 64'(0));
                    collecting = 1'b0;
                end else begin
                    re = rsp_q.pop_front();
                    if (re.exp_n >= 0) check("ncr_start_delay", 64'(since_valid), 64'(re.exp_n));
                    collecting = 1'b1;
                    nbits      = 0;
                end
            end
            if (!cmd_oe && prev_oe) begin
                check("idle_cmd_out", 64'(cmd_out), 64'(1));
                if (collecting) begin
                    check("rsp_length", 64'(nbits), 64'(48));
                    collecting = 1'b0;
                end
            end
            if (bit_en) begin
                since_valid++;
                if (collecting && cmd_oe) begin
                    got = {got[46:0], cmd_out};
                    nbits++;
                    if (nbits == 48) begin
                        check("rsp_frame", 64'(got), 64'(re.frame));
                        collecting = 1'b0;
                    end
                end
            end
            prev_oe = cmd_oe;
        end
    end

    task automatic wait_bit();
        do @(negedge clk); while (!bit_en);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n) wait_bit();
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            wait_bit();
        end
        cmd_in = 1'b1;
    endtask

    task automatic handshake(input bit skip, input logic [5:0] ridx, input logic [31:0] st);
        @(negedge clk);
        rsp_valid  = 1'b1;
        rsp_skip   = skip;
        rsp_index  = ridx;
        rsp_status = st;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_skip  = 1'b0;
        check("rsp_ready_drop", 64'(rsp_ready), 64'(0));
    endtask

    task automatic wait_tx_done();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || collecting || cmd_oe) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_done_in_time", 64'(n < 3000), 64'(1));
    endtask

    // Issue one host frame; expectations come from the model before driving
    task automatic cmd_txn(input logic [47:0] f, input bit respond, input bit skip,
                           input logic [5:0] ridx, input logic [31:0] st);
        bit err;
        err = (f[7:1] != crc7(f[47:8])) || !f[0];
        if (f[46]) cmd_q.push_back('{idx: f[45:40], arg: f[39:8], err: err});
        if (f[46] && !err && respond && !skip)
            rsp_q.push_back('{frame: make_rsp(ridx, st), exp_n: int'(NCR_MIN) + 1});
        send_frame(f);
        if (f[46]) begin
            if (err) begin
                bit bad;
                bad = 1'b0;
                repeat (3) begin
                    wait_bit();
                    if (rsp_ready) bad = 1'b1;
                end
                check("rsp_ready_after_err", 64'(bad), 64'(0));
            end else begin
                check("rsp_ready_set", 64'(rsp_ready), 64'(1));
                if (respond) begin
                    handshake(skip, ridx, st);
                    if (!skip) wait_tx_done();
                end
            end
        end
        if (!(f[46] && !err && !respond)) idle_bits(4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: bench did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        logic [47:0] f;
        bit          seen;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_out", 64'(cmd_out), 64'(1));
        check("rst_cmd_oe", 64'(cmd_oe), 64'(0));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_cmd_err", 64'(cmd_err), 64'(0));
        check("rst_rsp_ready", 64'(rsp_ready), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        check("rst_cmd_index", 64'(cmd_index), 64'(0));
        check("rst_cmd_arg", 64'(cmd_arg), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        idle_bits(3);

        // CMD0 with skip, CMD8 answered, CMD0 with bad CRC
        cmd_txn(48'h40_00000000_95, 1'b1, 1'b1, 6'd0, 32'h0);
        cmd_txn(48'h48_000001AA_87, 1'b1, 1'b0, 6'd8, 32'h000001AA);
        cmd_txn(48'h40_00000000_97, 1'b1, 1'b0, 6'd0, 32'h0);

        // Card-direction frame ignored, then CMD55
        cmd_txn(48'h00_00000000_00, 1'b1, 1'b0, 6'd0, 32'h0);
        cmd_txn(48'h77_00000000_65, 1'b1, 1'b0, 6'd55, 32'h00000120);

        // Host never answers
        cmd_txn(make_cmd(6'd13, 32'h1234_0000), 1'b0, 1'b0, 6'd0, 32'h0);
`ifdef SD_RSP_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            wait_bit();
            n++;
            if (rsp_timeout) seen = 1'b1;
        end
        check("timeout_bits", 64'(n), 64'(NCR_MAX));
        check("timeout_rsp_ready", 64'(rsp_ready), 64'(0));
        idle_bits(4);
`else
        seen = 1'b0;
        repeat (NCR_MAX + 16) begin
            wait_bit();
            if (rsp_timeout || !rsp_ready) seen = 1'b1;
        end
        check("no_timeout", 64'(seen), 64'(0));
        rsp_q.push_back('{frame: make_rsp(6'd13, 32'h0000_0900), exp_n: -1});
        handshake(1'b0, 6'd13, 32'h0000_0900);
        wait_tx_done();
        idle_bits(4);
`endif

        // Reset while response bit 20 is on the line
        cmd_q.push_back('{idx: 6'd17, arg: 32'h0000_0200, err: 1'b0});
        rsp_q.push_back('{frame: make_rsp(6'd17, 32'hDEAD_BEEF), exp_n: int'(NCR_MIN) + 1});
        send_frame(make_cmd(6'd17, 32'h0000_0200));
        handshake(1'b0, 6'd17, 32'hDEAD_BEEF);
        n = 0;
        while (!cmd_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_started", 64'(cmd_oe), 64'(1));
        idle_bits(19);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_tx_reset_oe", 64'(cmd_oe), 64'(0));
        check("mid_tx_reset_out", 64'(cmd_out), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        idle_bits(3);
        cmd_txn(48'h40_00000000_95, 1'b1, 1'b1, 6'd0, 32'h0);

        // Randomised traffic
        for (int k = 0; k < 12; k++) begin
            logic [5:0]  idx, ridx;
            logic [31:0] arg, st;
            int          mode;
            idx  = 6'($urandom_range(63, 0));
            arg  = $urandom;
            ridx = 6'($urandom_range(63, 0));
            st   = $urandom;
            mode = int'($urandom_range(5, 0));
            f = make_cmd(idx, arg);
            if (mode == 0) f[1 + int'($urandom_range(6, 0))] ^= 1'b1;
            if (mode == 1) f[0] = 1'b0;
            cmd_txn(f, 1'b1, mode == 2, ridx, st);
        end

        idle_bits(8);
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
